// File: rtl/onehot_strobe_decoder_pkg.sv
// Shared definitions for the one-hot strobe decoder and its matching one-hot encoder.
// Line vectors are computed at LinesMaxW bits and truncated by the user to its line count.
package onehot_strobe_decoder_pkg;

  localparam int unsigned LinesMaxW = 32;
  localparam int unsigned CodeMaxW  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } state_e;

  function automatic logic [LinesMaxW-1:0] onehot_of(input logic [CodeMaxW-1:0] code);
    logic [LinesMaxW-1:0] one;
    one = LinesMaxW'(1);
    return one << code;
  endfunction

  // Encoder side: index of the lowest set line, 0 when no line is set.
  function automatic logic [CodeMaxW-1:0] binary_of(input logic [LinesMaxW-1:0] lines);
    logic [CodeMaxW-1:0] idx;
    idx = '0;
    for (int i = LinesMaxW - 1; i >= 0; i--) begin
      if (lines[i]) idx = CodeMaxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_strobe_decoder_strobe_timer.sv
// Loadable down-counter that saturates at zero; load takes priority over decrement.
module onehot_strobe_decoder_strobe_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero  = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/onehot_strobe_decoder.sv
// Registered binary-to-one-hot decoder: accepts a code, strobes one line for HOLD_CYCLES,
// then keeps all lines low for GAP_CYCLES before accepting again.
module onehot_strobe_decoder
  import onehot_strobe_decoder_pkg::*;
#(
  parameter int unsigned N_OUT       = 8,
  parameter int unsigned CODE_W      = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_ready,
  output logic [N_OUT-1:0]  o_lines,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  state_e             r_state, w_state_d;
  logic [N_OUT-1:0]   r_lines, w_lines_d;
  logic               r_done, w_done_d;
  logic               r_err, w_err_d;
  logic               w_xfer, w_code_ok;
  logic               w_load, w_dec, w_zero;
  logic [CNT_W-1:0]   w_load_val, w_count, w_count_d;
  logic [N_OUT-1:0]   w_onehot;

  assign o_ready   = (r_state == StIdle) && !i_clr;
  assign w_xfer    = i_valid && o_ready;
  assign w_code_ok = 32'(i_code) < N_OUT;
  assign w_onehot  = N_OUT'(onehot_of(CodeMaxW'(i_code)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_lines <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_lines <= w_lines_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_lines_d  = r_lines;
    w_err_d    = 1'b0;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    if (i_clr) begin
      w_state_d = StIdle;
      w_lines_d = '0;
      w_load    = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_xfer) begin
            if (w_code_ok) begin
              w_state_d  = StDrive;
              w_lines_d  = w_onehot;
              w_load     = 1'b1;
              w_load_val = CNT_W'(HOLD_CYCLES - 1);
            end else begin
              w_err_d = 1'b1;
            end
          end
        end
        StDrive: begin
          if (w_zero) begin
            w_lines_d = '0;
            if (GAP_CYCLES > 0) begin
              w_state_d  = StGap;
              w_load     = 1'b1;
              w_load_val = CNT_W'(GAP_CYCLES - 1);
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_dec = 1'b1;
          end
        end
        StGap: begin
          if (w_zero) w_state_d = StIdle;
          else        w_dec     = 1'b1;
        end
        default: begin
          w_state_d = StIdle;
          w_lines_d = '0;
        end
      endcase
    end
  end

  // done is registered, so it is raised on the edge entering the final phase cycle.
  always_comb begin
    w_count_d = w_load ? w_load_val : (w_dec ? (w_count - CNT_W'(1)) : w_count);
    w_done_d  = 1'b0;
    if (!i_clr && (w_count_d == '0)) begin
      w_done_d = (GAP_CYCLES > 0) ? (w_state_d == StGap) : (w_state_d == StDrive);
    end
  end

  onehot_strobe_decoder_strobe_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero),
    .o_count    (w_count)
  );

  assign o_lines = r_lines;
  assign o_busy  = (r_state != StIdle);
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Directed bench for onehot_strobe_decoder: default, N_OUT=6, and HOLD=1/GAP=0 instances.
module tb_onehot_strobe_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_clr, a_valid, a_ready, a_busy, a_done, a_err;
  logic [2:0] a_code;
  logic [7:0] a_lines;
  logic       b_clr, b_valid, b_ready, b_busy, b_done, b_err;
  logic [2:0] b_code;
  logic [5:0] b_lines;
  logic       c_clr, c_valid, c_ready, c_busy, c_done, c_err;
  logic [2:0] c_code;
  logic [7:0] c_lines;

  onehot_strobe_decoder u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_clr(a_clr), .i_valid(a_valid), .i_code(a_code),
    .o_ready(a_ready), .o_lines(a_lines), .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
  );

  onehot_strobe_decoder #(.N_OUT(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_clr(b_clr), .i_valid(b_valid), .i_code(b_code),
    .o_ready(b_ready), .o_lines(b_lines), .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
  );

  onehot_strobe_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .i_clr(c_clr), .i_valid(c_valid), .i_code(c_code),
    .o_ready(c_ready), .o_lines(c_lines), .o_busy(c_busy), .o_done(c_done), .o_err(c_err)
  );

  typedef struct {
    int         dut;
    logic       valid;
    logic [2:0] code;
    logic       clr;
    logic [7:0] lines;
    logic       busy;
    logic       done;
    logic       err;
    logic       ready;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int dut, input logic valid, input logic [2:0] code,
                              input logic clr, input logic [7:0] lines, input logic busy,
                              input logic done, input logic err, input logic ready);
    vec_t v;
    v.dut = dut; v.valid = valid; v.code = code; v.clr = clr; v.lines = lines;
    v.busy = busy; v.done = done; v.err = err; v.ready = ready;
    return v;
  endfunction

  task automatic idle_inputs();
    a_clr = 0; a_valid = 0;
    b_clr = 0; b_valid = 0;
    c_clr = 0; c_valid = 0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    logic [7:0] l;
    logic       bz, dn, er, rd;
    idle_inputs();
    case (v.dut)
      0:       begin a_valid = v.valid; a_code = v.code; a_clr = v.clr; end
      1:       begin b_valid = v.valid; b_code = v.code; b_clr = v.clr; end
      default: begin c_valid = v.valid; c_code = v.code; c_clr = v.clr; end
    endcase
    @(posedge clk);
    #1;
    case (v.dut)
      0:       begin l = a_lines; bz = a_busy; dn = a_done; er = a_err; rd = a_ready; end
      1:       begin l = {2'b00, b_lines}; bz = b_busy; dn = b_done; er = b_err; rd = b_ready; end
      default: begin l = c_lines; bz = c_busy; dn = c_done; er = c_err; rd = c_ready; end
    endcase
    check($sformatf("vec%0d lines", idx), 32'(l), 32'(v.lines));
    check($sformatf("vec%0d busy", idx), 32'(bz), 32'(v.busy));
    check($sformatf("vec%0d done", idx), 32'(dn), 32'(v.done));
    check($sformatf("vec%0d err", idx), 32'(er), 32'(v.err));
    check($sformatf("vec%0d ready", idx), 32'(rd), 32'(v.ready));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int         n_done;
    logic [7:0] exp_l;

    // dut, valid, code, clr | lines, busy, done, err, ready
    // Default instance: strobe of code 5 straight out of reset.
    tbl.push_back(mk(0, 1, 3'd5, 0, 8'h20, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 8'h20, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 8'h20, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 8'h20, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 1));
    // Default instance: clr during the 2nd DRIVE cycle of code 3.
    tbl.push_back(mk(0, 1, 3'd3, 0, 8'h08, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 8'h08, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd6, 1, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd6, 1, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 1));
    // N_OUT=6 instance: out-of-range codes 6, 7 then code 2.
    tbl.push_back(mk(1, 1, 3'd6, 0, 8'h00, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 3'd7, 0, 8'h00, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 3'd2, 0, 8'h04, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd0, 0, 8'h04, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd0, 0, 8'h04, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd0, 0, 8'h04, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd0, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 3'd0, 0, 8'h00, 0, 0, 0, 1));
    // HOLD=1, GAP=0 instance: code 1, ignored code 7 while driving, then code 4.
    tbl.push_back(mk(2, 1, 3'd1, 0, 8'h02, 1, 1, 0, 0));
    tbl.push_back(mk(2, 1, 3'd7, 0, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(2, 1, 3'd4, 0, 8'h10, 1, 1, 0, 0));
    tbl.push_back(mk(2, 0, 3'd0, 0, 8'h00, 0, 0, 0, 1));

    // Reset held with a pending request; nothing may come out.
    rst_n = 1'b0;
    idle_inputs();
    a_valid = 1; a_code = 3'd5; b_code = 0; c_code = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset lines", 32'(a_lines), 32'h0);
    check("reset busy", 32'(a_busy), 32'h0);
    check("reset done", 32'(a_done), 32'h0);
    check("reset err", 32'(a_err), 32'h0);
    check("reset ready", 32'(a_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // Back-to-back sweep with valid held high: one strobe every 6 cycles.
    idle_inputs();
    n_done = 0;
    a_valid = 1; a_code = 3'd0;
    for (int k = 0; k < 8; k++) begin
      exp_l = 8'h01 << k;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk);
        #1;
        if (a_done) n_done++;
        check($sformatf("sweep onehot k%0d c%0d", k, c), 32'($onehot0(a_lines)), 32'h1);
        if (c < 4) begin
          check($sformatf("sweep lines k%0d c%0d", k, c), 32'(a_lines), 32'(exp_l));
          check($sformatf("sweep ready k%0d c%0d", k, c), 32'(a_ready), 32'h0);
        end else if (c == 4) begin
          check($sformatf("sweep gap lines k%0d", k), 32'(a_lines), 32'h0);
          check($sformatf("sweep done k%0d", k), 32'(a_done), 32'h1);
        end else begin
          check($sformatf("sweep idle busy k%0d", k), 32'(a_busy), 32'h0);
          check($sformatf("sweep idle ready k%0d", k), 32'(a_ready), 32'h1);
          if (k < 7) a_code = 3'(k + 1);
          else       a_valid = 0;
        end
      end
    end
    check("sweep done count", 32'(n_done), 32'd8);

    // Asynchronous reset in the middle of the GAP cycle.
    a_valid = 1; a_code = 3'd1;
    @(posedge clk);
    #1;
    check("rstgap strobe", 32'(a_lines), 32'h02);
    a_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rstgap in gap", 32'(a_done), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstgap lines", 32'(a_lines), 32'h0);
    check("rstgap done", 32'(a_done), 32'h0);
    check("rstgap busy", 32'(a_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1; a_code = 3'd6;
    @(posedge clk);
    #1;
    check("post-reset strobe", 32'(a_lines), 32'h40);
    check("post-reset err", 32'(a_err), 32'h0);
    a_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    check("post-reset idle", 32'(a_busy), 32'h0);
    check("post-reset ready", 32'(a_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
